expmul_accum: RTL and testbench

EXPMUL_ACCUM -- requirements
Module: expmul_accum

---
 rtl/expmul_accum.sv | 89 ++++++++
 tb/tb_expmul_accum.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/expmul_accum.sv
// Row accumulator behind the expmul stage: sums rescaled and exp-weighted lanes
// per key, feeds the running value back upstream, and hands each finished row downstream.
module expmul_accum #(
  parameter int W        = 16,
  parameter int D        = 4,
  parameter int NUM_KEYS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  output logic             rdy_out,
  input  logic [D*W-1:0]   exp_o_in,
  input  logic [D*W-1:0]   exp_v_in,
  output logic [D*W-1:0]   o_star_prev_out,
  output logic             vld_out,
  input  logic             rdy_in,
  output logic [D*W-1:0]   o_out
);

  localparam int CW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_KEYS - 1);

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [D*W-1:0] acc_q, acc_d;
  logic [D*W-1:0] out_q, out_d;
  logic [D*W-1:0] sum;
  logic           accept;
  logic           emit;

  // Per-lane add at W+1 bits; an overflow shows up as the top two bits differing.
  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_lane
      logic [W:0] wide;
      assign wide = {exp_o_in[gi*W+W-1], exp_o_in[gi*W +: W]}
                  + {exp_v_in[gi*W+W-1], exp_v_in[gi*W +: W]};
      assign sum[gi*W +: W] = (wide[W] != wide[W-1])
                            ? (wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                            : wide[W-1:0];
    end
  endgenerate

  assign rdy_out         = !rst && ((state_q == ACCUM) || rdy_in);
  assign vld_out         = (state_q == DRAIN);
  assign o_out           = out_q;
  assign o_star_prev_out = (cnt_q == '0) ? '0 : acc_q;

  assign accept = vld_in && rdy_out;
  assign emit   = vld_out && rdy_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    if (emit) begin
      state_d = ACCUM;
    end
    // A key accepted during DRAIN always coincides with an emit, so the
    // final-key branch below may re-enter DRAIN in that same cycle.
    if (accept) begin
      acc_d = sum;
      if (cnt_q == LAST) begin
        out_d   = sum;
        cnt_d   = '0;
        state_d = DRAIN;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_expmul_accum.sv
// Scoreboard bench for expmul_accum: a behavioural row model predicts handshakes,
// feedback and finished rows; a separate monitor checks each emitted row.
module tb_expmul_accum;

  localparam int W  = 16;
  localparam int D  = 2;
  localparam int NK = 4;

  typedef logic [D*W-1:0] row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld_in = 1'b0;
  logic rdy_in = 1'b0;
  row_t exp_o_in = '0;
  row_t exp_v_in = '0;
  logic rdy_out, vld_out;
  row_t o_star_prev_out, o_out;

  always #5 clk = ~clk;

  expmul_accum #(.W(W), .D(D), .NUM_KEYS(NK)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
    .exp_o_in(exp_o_in), .exp_v_in(exp_v_in), .o_star_prev_out(o_star_prev_out),
    .vld_out(vld_out), .rdy_in(rdy_in), .o_out(o_out)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  row_t sb[$];

  // Model state: whether a finished row is pending, keys taken in this row,
  // last saturated sum and the held finished row.
  bit   m_drain = 1'b0;
  int   m_cnt   = 0;
  row_t m_acc   = '0;
  row_t m_out   = '0;

  task automatic chk(input string nm, input row_t act, input row_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  function automatic row_t sat_row(input row_t a, input row_t b);
    row_t r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      int s;
      s = int'($signed(a[i*W +: W])) + int'($signed(b[i*W +: W]));
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      r[i*W +: W] = s[W-1:0];
    end
    return r;
  endfunction

  function automatic row_t m_prev();
    return (m_cnt == 0) ? '0 : m_acc;
  endfunction

  function automatic row_t rnd_row();
    row_t r;
    for (int i = 0; i < D; i++) r[i*W +: W] = W'($urandom_range(0, 65535));
    return r;
  endfunction

  // Reference model: checks handshake/feedback outputs, then advances and
  // pushes each completed row onto the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rdy_out", row_t'(rdy_out), '0);
      chk("rst_vld_out", row_t'(vld_out), '0);
      chk("rst_o_out", o_out, '0);
      chk("rst_prev", o_star_prev_out, '0);
      m_drain = 1'b0;
      m_cnt   = 0;
      m_acc   = '0;
      m_out   = '0;
      sb.delete();
    end else begin
      bit   exp_rdy, acc_ok;
      row_t s;
      exp_rdy = !m_drain || rdy_in;
      chk("rdy_out", row_t'(rdy_out), row_t'(exp_rdy));
      chk("vld_out", row_t'(vld_out), row_t'(m_drain));
      chk("o_star_prev_out", o_star_prev_out, m_prev());
      chk("o_out_held", o_out, m_out);
      acc_ok = vld_in && exp_rdy;
      if (m_drain && rdy_in) m_drain = 1'b0;
      if (acc_ok) begin
        s     = sat_row(exp_o_in, exp_v_in);
        m_acc = s;
        if (m_cnt == NK - 1) begin
          m_out   = s;
          m_cnt   = 0;
          m_drain = 1'b1;
          sb.push_back(s);
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Monitor: every emitted row must match the oldest expected row.
  always @(negedge clk) begin
    if (!rst && vld_out && rdy_in) begin
      if (sb.size() == 0) begin
        chk("unexpected_row", o_out, 'x);
      end else begin
        row_t e;
        e = sb.pop_front();
        chk("row", o_out, e);
      end
    end
  end

  // One cycle of stimulus; fb selects the model's predicted feedback as exp_o_in.
  task automatic step(input bit v, input bit r, input bit fb, input row_t eo, input row_t ev);
    @(posedge clk);
    #1;
    vld_in   = v;
    rdy_in   = r;
    exp_o_in = fb ? m_prev() : eo;
    exp_v_in = ev;
  endtask

  localparam row_t K100 = {16'h0100, 16'h0100};
  localparam row_t K400 = {16'h0400, 16'h0400};
  localparam row_t K010 = {16'h0010, 16'h0010};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Normal row: feedback accumulation of 0x0100 per key.
    for (int k = 0; k < NK; k++) step(1, 0, 1, '0, K100);
    step(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("normal_row", o_out, K400);
    step(0, 1, 0, '0, '0);

    // Saturation on the final key, both directions.
    for (int k = 0; k < NK - 1; k++) step(1, 1, 0, rnd_row(), rnd_row());
    step(1, 0, 0, {16'h7F00, 16'h8100}, {16'h0200, 16'hFE00});
    step(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("saturate", o_out, {16'h7FFF, 16'h8000});

    // Backpressure while upstream keeps offering data.
    repeat (5) step(1, 0, 0, rnd_row(), rnd_row());
    @(negedge clk);
    chk("bp_o_out", o_out, {16'h7FFF, 16'h8000});
    chk("bp_rdy_out", row_t'(rdy_out), '0);

    // Emit and accept in the same cycle.
    step(1, 1, 0, '0, K010);
    @(negedge clk);
    chk("ea_prev", o_star_prev_out, '0);
    chk("ea_vld", row_t'(vld_out), row_t'(1'b1));
    step(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("ea_acc", o_star_prev_out, K010);
    chk("ea_state", row_t'(vld_out), '0);
    for (int k = 1; k < NK; k++) step(1, 1, 1, '0, K100);
    step(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("ea_row", o_out, {16'h0310, 16'h0310});
    step(0, 1, 0, '0, '0);

    // Reset in the middle of a row.
    step(1, 1, 1, '0, K100);
    step(1, 1, 1, '0, K100);
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    rst    = 1'b1;
    #1;
    chk("mid_rst_prev", o_star_prev_out, '0);
    chk("mid_rst_vld", row_t'(vld_out), '0);
    chk("mid_rst_rdy", row_t'(rdy_out), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < NK; k++) step(1, 1, 1, '0, K100);
    step(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("post_rst_row", o_out, K400);
    step(0, 1, 0, '0, '0);

    // Idle gaps between keys.
    for (int k = 0; k < NK; k++) begin
      step(1, 1, 1, '0, K100);
      if (k < NK - 1) repeat (3) step(0, 1, 0, rnd_row(), rnd_row());
    end
    step(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("gap_row", o_out, K400);
    step(0, 1, 0, '0, '0);

    // Randomized traffic with random handshakes and mixed feedback.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           $urandom_range(0, 1) == 1, rnd_row(), rnd_row());
    end

    repeat (4) step(0, 1, 0, '0, '0);
    @(negedge clk);
    chk("sb_empty", row_t'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
